// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline control sequencer.
package pipeline_ctrl_pkg;

    localparam int REG_W_DEF = 5;
    localparam int CNT_W_DEF = 32;

    typedef logic [REG_W_DEF-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the control sequencer (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) ();
    logic             ihit;
    logic             dhit;
    logic             dmemr_mem;
    logic             dmemw_mem;
    logic             dmemr_exe;
    logic             WEN_exe;
    logic [REG_W-1:0] rd_exe;
    logic [REG_W-1:0] rs1_id;
    logic [REG_W-1:0] rs2_id;
    logic             use_rs1_id;
    logic             use_rs2_id;
    logic             redirect_exe;
    logic             halt_id;
    logic             halt_wb;

    logic             pc_en;
    logic             pc_redirect;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             hazard_detected;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, dmemr_mem, dmemw_mem, dmemr_exe, WEN_exe, rd_exe,
               rs1_id, rs2_id, use_rs1_id, use_rs2_id, redirect_exe, halt_id, halt_wb,
        input  pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, hazard_detected, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, dmemr_mem, dmemw_mem, dmemr_exe, WEN_exe, rd_exe,
               rs1_id, rs2_id, use_rs1_id, use_rs2_id, redirect_exe, halt_id, halt_wb,
        output pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, hazard_detected, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use compare: a load in EX whose destination feeds a source the ID instruction reads.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             dmemr_exe,
    input  logic             WEN_exe,
    input  logic [REG_W-1:0] rd_exe,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             use_rs1_id,
    input  logic             use_rs2_id,
    output logic             lu
);
    logic rs1_hit_s;
    logic rs2_hit_s;

    assign rs1_hit_s = use_rs1_id & (rs1_id == rd_exe);
    assign rs2_hit_s = use_rs2_id & (rs2_id == rd_exe);
    // x0 is hard-wired zero, so a load into it never creates a dependency
    assign lu = dmemr_exe & WEN_exe & (rd_exe != {REG_W{1'b0}}) & (rs1_hit_s | rs2_hit_s);
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline register sequencer: enables, flushes, PC control, halt drain and perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    pipeline_ctrl_if.slave bus
);
    ctrl_state_t      state_r;
    ctrl_state_t      state_next_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    logic dmem_busy_s;
    logic halted_s;
    logic advance_s;
    logic lu_s;
    logic pc_en_s;
    logic pc_redirect_s;
    logic ifid_en_s;
    logic rest_en_s;
    logic ifid_flush_s;
    logic idex_flush_s;
    logic hazard_s;
    logic stall_inc_s;
    logic flush_inc_s;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .dmemr_exe  (bus.dmemr_exe),
        .WEN_exe    (bus.WEN_exe),
        .rd_exe     (bus.rd_exe),
        .rs1_id     (bus.rs1_id),
        .rs2_id     (bus.rs2_id),
        .use_rs1_id (bus.use_rs1_id),
        .use_rs2_id (bus.use_rs2_id),
        .lu         (lu_s)
    );

    assign dmem_busy_s = (bus.dmemr_mem | bus.dmemw_mem) & ~bus.dhit;
    assign halted_s    = (state_r == HALTED);
    assign advance_s   = bus.ihit & ~dmem_busy_s & ~halted_s;

    // Per-cycle strobes: redirect beats load-use beats normal; frozen cycles drive nothing
    always_comb begin
        pc_en_s       = 1'b0;
        pc_redirect_s = 1'b0;
        ifid_en_s     = 1'b0;
        rest_en_s     = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_flush_s  = 1'b0;
        hazard_s      = 1'b0;
        if (advance_s) begin
            ifid_en_s = 1'b1;
            rest_en_s = 1'b1;
            if (bus.redirect_exe) begin
                pc_en_s       = 1'b1;
                pc_redirect_s = 1'b1;
                ifid_flush_s  = 1'b1;
                idex_flush_s  = 1'b1;
            end else if (lu_s) begin
                ifid_en_s    = 1'b0;
                idex_flush_s = 1'b1;
                hazard_s     = 1'b1;
            end else begin
                pc_en_s      = (state_r != DRAIN);
                ifid_flush_s = (state_r == DRAIN);
            end
        end else begin
            pc_en_s = 1'b0;
        end
    end

    // Halt-drain next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (advance_s & bus.halt_id & ~bus.redirect_exe & ~lu_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (advance_s & bus.redirect_exe) begin
                    state_next_s = RUN;
                end else if (bus.halt_wb) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = RUN;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign stall_inc_s = (~advance_s | hazard_s) & ~halted_s;
    assign flush_inc_s = advance_s & bus.redirect_exe;

    // Saturating performance counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.pc_en           = pc_en_s;
    assign bus.pc_redirect     = pc_redirect_s;
    assign bus.ifid_en         = ifid_en_s;
    assign bus.idex_en         = rest_en_s;
    assign bus.exmem_en        = rest_en_s;
    assign bus.memwb_en        = rest_en_s;
    assign bus.ifid_flush      = ifid_flush_s;
    assign bus.idex_flush      = idex_flush_s;
    assign bus.hazard_detected = hazard_s;
    assign bus.halted          = halted_s;
    assign bus.stall_cnt       = stall_cnt_r;
    assign bus.flush_cnt       = flush_cnt_r;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl with 4-bit counters to reach saturation quickly.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;

    pipeline_ctrl_if #(.CNT_W(4), .REG_W(5)) bus ();

    pipeline_ctrl #(.CNT_W(4), .REG_W(5)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bit order: pc_en pc_redirect ifid_en idex_en exmem_en memwb_en ifid_flush idex_flush hazard halted
    localparam logic [9:0] O_NORM  = 10'b1011110000;
    localparam logic [9:0] O_LU    = 10'b0001110110;
    localparam logic [9:0] O_REDIR = 10'b1111111100;
    localparam logic [9:0] O_FROZE = 10'b0000000000;
    localparam logic [9:0] O_DRAIN = 10'b0011111000;
    localparam logic [9:0] O_HALT  = 10'b0000000001;

    typedef struct {
        logic [9:0] o;
        logic [3:0] s;
        logic [3:0] f;
        int         id;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input logic ih);
        bus.ihit         = ih;
        bus.dhit         = 1'b0;
        bus.dmemr_mem    = 1'b0;
        bus.dmemw_mem    = 1'b0;
        bus.dmemr_exe    = 1'b0;
        bus.WEN_exe      = 1'b0;
        bus.rd_exe       = 5'd0;
        bus.rs1_id       = 5'd0;
        bus.rs2_id       = 5'd0;
        bus.use_rs1_id   = 1'b0;
        bus.use_rs2_id   = 1'b0;
        bus.redirect_exe = 1'b0;
        bus.halt_id      = 1'b0;
        bus.halt_wb      = 1'b0;
    endtask

    task automatic expect_v(input logic [9:0] o, input logic [3:0] s, input logic [3:0] f);
        exp_t e;
        e.o  = o;
        e.s  = s;
        e.f  = f;
        e.id = vec_id;
        q.push_back(e);
        vec_id++;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        bus.dmemr_exe  = 1'b1;
        bus.WEN_exe    = 1'b1;
        bus.rd_exe     = rd;
        bus.rs2_id     = 5'd5;
        bus.use_rs2_id = 1'b1;
    endtask

    // Monitor: pops one expectation per cycle mid-period and compares
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e   = q.pop_front();
            act = {bus.pc_en, bus.pc_redirect, bus.ifid_en, bus.idex_en, bus.exmem_en,
                   bus.memwb_en, bus.ifid_flush, bus.idex_flush, bus.hazard_detected, bus.halted};
            checks++;
            if (act !== e.o) begin
                failures++;
                $display("FAIL outputs vec=%0d actual=%b required=%b", e.id, act, e.o);
            end
            checks++;
            if (bus.stall_cnt !== e.s) begin
                failures++;
                $display("FAIL stall_cnt vec=%0d actual=%0d required=%0d", e.id, bus.stall_cnt, e.s);
            end
            checks++;
            if (bus.flush_cnt !== e.f) begin
                failures++;
                $display("FAIL flush_cnt vec=%0d actual=%0d required=%0d", e.id, bus.flush_cnt, e.f);
            end
        end
    end

    initial begin
        rst = 1'b1;
        clr(1'b0);
        tick();
        expect_v(O_FROZE, 4'd0, 4'd0);
        tick();
        rst = 1'b0;
        clr(1'b1);
        expect_v(O_NORM, 4'd0, 4'd0);

        // Load-use, then the same with rd_exe=0
        tick(); clr(1'b1); set_lu(5'd5); expect_v(O_LU,   4'd0, 4'd0);
        tick(); clr(1'b1); set_lu(5'd0); expect_v(O_NORM, 4'd1, 4'd0);

        // Redirect beats a simultaneous load-use
        tick(); clr(1'b1); set_lu(5'd5); bus.redirect_exe = 1'b1; expect_v(O_REDIR, 4'd1, 4'd0);
        tick(); clr(1'b1); expect_v(O_NORM, 4'd1, 4'd1);

        // Store miss for 3 cycles with a held redirect, applied once on release
        for (int i = 0; i < 3; i++) begin
            tick(); clr(1'b1); bus.dmemw_mem = 1'b1; bus.redirect_exe = 1'b1;
            expect_v(O_FROZE, 4'(1 + i), 4'd1);
        end
        tick(); clr(1'b1); bus.dmemw_mem = 1'b1; bus.dhit = 1'b1; bus.redirect_exe = 1'b1;
        expect_v(O_REDIR, 4'd4, 4'd1);
        tick(); clr(1'b1); expect_v(O_NORM, 4'd4, 4'd2);

        // Halt drain to HALTED
        tick(); clr(1'b1); bus.halt_id = 1'b1; expect_v(O_NORM,  4'd4, 4'd2);
        tick(); clr(1'b1); expect_v(O_DRAIN, 4'd4, 4'd2);
        tick(); clr(1'b1); expect_v(O_DRAIN, 4'd4, 4'd2);
        tick(); clr(1'b1); bus.halt_wb = 1'b1; expect_v(O_DRAIN, 4'd4, 4'd2);
        tick(); clr(1'b1); expect_v(O_HALT, 4'd4, 4'd2);
        tick(); clr(1'b1); bus.redirect_exe = 1'b1; expect_v(O_HALT, 4'd4, 4'd2);
        tick(); clr(1'b1); expect_v(O_HALT, 4'd4, 4'd2);
        tick(); clr(1'b1); rst = 1'b1; expect_v(O_HALT, 4'd4, 4'd2);
        tick(); clr(1'b1); rst = 1'b0; expect_v(O_NORM, 4'd0, 4'd0);

        // Second run: redirect during drain returns to RUN
        tick(); clr(1'b1); bus.halt_id = 1'b1; expect_v(O_NORM, 4'd0, 4'd0);
        tick(); clr(1'b1); expect_v(O_DRAIN, 4'd0, 4'd0);
        tick(); clr(1'b1); bus.redirect_exe = 1'b1; expect_v(O_REDIR, 4'd0, 4'd0);
        tick(); clr(1'b1); expect_v(O_NORM, 4'd0, 4'd1);

        // Stall counter saturation over 20 frozen cycles
        for (int i = 0; i < 20; i++) begin
            tick(); clr(1'b0);
            expect_v(O_FROZE, (i < 15) ? 4'(i) : 4'd15, 4'd1);
        end
        tick(); clr(1'b1); expect_v(O_NORM, 4'd15, 4'd1);

        // Reset in the middle of a drain
        tick(); clr(1'b1); bus.halt_id = 1'b1; expect_v(O_NORM, 4'd15, 4'd1);
        tick(); clr(1'b1); expect_v(O_DRAIN, 4'd15, 4'd1);
        tick(); clr(1'b1); rst = 1'b1; expect_v(O_DRAIN, 4'd15, 4'd1);
        tick(); clr(1'b1); rst = 1'b0; expect_v(O_NORM, 4'd0, 4'd0);
        tick(); clr(1'b1); expect_v(O_NORM, 4'd0, 4'd0);

        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Produces per-register enable and flush strobes, the PC enable, and the PC redirect select.
- Inputs it acts on: cache hits, load-use hazards, EX-stage redirects and the halt instruction.
- Holds a halt-drain state machine and saturating stall/flush performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- REG_W, 5, width of register-index fields.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- dmemr_mem, dmemw_mem  in  1 each  MEM stage holds a load / store.
- dmemr_exe  in  1  EX stage holds a load.
- WEN_exe  in  1  EX instruction writes the register file.
- rd_exe  in  REG_W  EX destination register.
- rs1_id, rs2_id  in  REG_W each  ID source registers.
- use_rs1_id, use_rs2_id  in  1 each  ID instruction actually reads rs1 / rs2.
- redirect_exe  in  1  taken branch, jal or jalr resolved in EX.
- halt_id  in  1  halt decoded in ID.
- halt_wb  in  1  halt has reached MEM/WB output.
- pc_en  out  1  PC may update.
- pc_redirect  out  1  PC selects the EX target.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register advance (pipeline_control).
- ifid_flush, idex_flush  out  1 each  load a bubble; only meaningful with the matching _en.
- hazard_detected  out  1  load-use bubble inserted this cycle.
- halted  out  1  sticky halt.
- stall_cnt  out  CNT_W  cycles with advance=0 or a load-use bubble.
- flush_cnt  out  CNT_W  redirects applied.

Behaviour:
- Reset: state=RUN, halted=0, both counters 0.
- Combinational outputs follow the rules below from cycle 0 after reset.
- dmem_busy = (dmemr_mem|dmemw_mem) & ~dhit.
- advance = ihit & ~dmem_busy & ~halted.
- Register enables: ifid_en = idex_en = exmem_en = memwb_en = advance. No partial-pipeline advance. Every register freezes together.
- Frozen cycle: all pipeline state and inputs are held stable. A redirect or hazard present while frozen is acted on in the first advance cycle. No latching is required.
- Load-use (lu):
  - lu = dmemr_exe & WEN_exe & rd_exe!=0 & ((use_rs1_id & rs1_id==rd_exe) | (use_rs2_id & rs2_id==rd_exe)).
- Priority per advance cycle: redirect > lu > normal.
  - Redirect: pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1, hazard_detected=0, flush_cnt+1.
  - lu (no redirect): pc_en=0, ifid_en forced 0 (hold ID), idex_flush=1, hazard_detected=1, stall_cnt+1.
  - Normal: pc_en=1, no flushes.
- Frozen: pc_en=0 and all flush outputs are 0.
- FSM states:
  - RUN: on an advance cycle with halt_id & ~redirect_exe & ~lu, go to DRAIN. The halt moves into ID/EX that cycle.
  - DRAIN: pc_en=0 and ifid_flush=1 on every advance, so fetch stops and bubbles fill behind the halt.
    - redirect_exe on an advance cycle (halt was squashed) -> RUN; normal redirect actions apply.
    - halt_wb -> HALTED.
  - HALTED: halted=1, advance=0, all enables 0, all flushes 0, pc_en=0. Exit only on RST.
- Counters:
  - Saturate at all-ones; never wrap.
  - stall_cnt increments when advance=0 or hazard_detected=1; it does not increment in HALTED.
  - flush_cnt increments on each applied redirect.
- RST mid-drain or mid-stall: immediate return to RUN with counters cleared next edge.
- RST has priority over every other event.

Decomposition:
- cpu_types_pkg gains:
  - ctrl_state_t enum {RUN, DRAIN, HALTED}.
  - regbits_t-width constant for REG_W.
- One natural sub-module: hazard_detect, the combinational lu compare. Instantiated once.
- FSM, counters and enable logic stay in pipeline_ctrl.

Test Plan:
1. RST=1 for 2 cycles, then ihit=1, no mem ops -> all *_en=1, pc_en=1, flushes 0, stall_cnt=0, flush_cnt=0.
2. dmemr_exe=1, WEN_exe=1, rd_exe=5, rs2_id=5, use_rs2_id=1, ihit=1 -> pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, hazard_detected=1, stall_cnt=1. Repeat with rd_exe=0 -> no hazard.
3. redirect_exe=1 together with a load-use match -> pc_redirect=1, ifid_flush=idex_flush=1, hazard_detected=0, flush_cnt=1.
4. dmemw_mem=1, dhit=0 for 3 cycles, then dhit=1 -> all enables 0 and stall_cnt=3 during the wait; advance on the 4th cycle. A redirect held during the wait is applied exactly once.
5. halt_id then halt_wb 3 cycles later -> DRAIN with pc_en=0 and ifid_flush=1, then halted=1 sticky with all enables 0. Second run: redirect_exe in DRAIN -> back to RUN, halted stays 0.
6. Force stall_cnt near all-ones (CNT_W=4, 20 frozen cycles) -> holds at 15. RST mid-DRAIN -> RUN and counters 0 next edge.
